// File: rtl/aftab_imm_gen_pipe.sv
// aftab_imm_gen_pipe
// Pipelined RISC-V immediate generator for the AFTAB datapath. Decodes the
// immediate selected by a format code, extends it to XLEN and presents it
// through a registered output stage with a one-entry skid buffer, so the
// upstream ready is purely a decode of registered state. Also keeps a
// saturating count of reserved format codes for the debug unit.
module aftab_imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_fmt,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_imm,
    output logic            o_imm_err,
    output logic [ERRW-1:0] o_err_cnt,
    input  logic            i_clr_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [XLEN-1:0]   r_m_imm;
    logic              r_m_err;
    logic [XLEN-1:0]   r_k_imm;
    logic              r_k_err;
    logic [ERRW-1:0]   r_err_cnt;

    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic              w_err;
    logic              w_accept;
    logic              w_deliver;
    logic              w_load_m_in;
    logic              w_load_m_k;
    logic              w_load_k;

    // The opcode field never contributes to any immediate.
    logic [6:0]        w_unused_opcode;
    assign w_unused_opcode = i_instr[6:0];

    // Handshake flags are decodes of the registered occupancy only.
    assign o_in_ready  = (r_state != S_FULL);
    assign o_out_valid = (r_state != S_EMPTY);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_deliver   = o_out_valid && i_out_ready;

    assign o_imm       = r_m_imm;
    assign o_imm_err   = r_m_err;
    assign o_err_cnt   = r_err_cnt;

    // Assemble the 32-bit immediate; zero-extended formats leave bit 31 clear
    // so a single sign extension below serves every format.
    always_comb begin
        w_imm32 = '0;
        w_err   = 1'b0;
        case (i_fmt)
            3'd0: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            3'd1: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            3'd2: w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
            3'd3: w_imm32 = {i_instr[31:12], 12'b0};
            3'd4: w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
            3'd5: w_imm32 = {27'b0, i_instr[19:15]};
            3'd6: begin
                if (XLEN == 64) begin
                    w_imm32 = {26'b0, i_instr[25:20]};
                end else begin
                    w_imm32 = {27'b0, i_instr[24:20]};
                end
            end
            default: begin
                w_imm32 = '0;
                w_err   = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN > 32) begin : g_ext
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_noext
            assign w_imm = w_imm32;
        end
    endgenerate

    // Next occupancy and which storage register loads on this edge.
    always_comb begin
        w_state_next = r_state;
        w_load_m_in  = 1'b0;
        w_load_m_k   = 1'b0;
        w_load_k     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_m_in  = 1'b1;
                    w_state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_m_in = 1'b1;
                end else if (w_deliver) begin
                    w_state_next = S_EMPTY;
                end else if (w_accept) begin
                    w_load_k     = 1'b1;
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (w_deliver) begin
                    w_load_m_k   = 1'b1;
                    w_state_next = S_ONE;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Main output register and skid register; reset drops any held entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_imm <= '0;
            r_m_err <= 1'b0;
            r_k_imm <= '0;
            r_k_err <= 1'b0;
        end else begin
            if (w_load_m_in) begin
                r_m_imm <= w_imm;
                r_m_err <= w_err;
            end else if (w_load_m_k) begin
                r_m_imm <= r_k_imm;
                r_m_err <= r_k_err;
            end
            if (w_load_k) begin
                r_k_imm <= w_imm;
                r_k_err <= w_err;
            end
        end
    end

    // Saturating count of accepted reserved-format entries; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (i_clr_err) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aftab_imm_gen_pipe.sv
// Bench for aftab_imm_gen_pipe: a 32-bit instance (ERRW=2) and a 64-bit
// instance (ERRW=8) share one stimulus stream. A queue-based occupancy model
// and an arithmetic immediate model are compared every cycle, alongside
// directed literal expectations.
module tb_aftab_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [31:0] i_instr = '0;
    logic [2:0]  i_fmt = '0;
    logic        i_out_ready = 1'b0;
    logic        i_clr_err = 1'b0;

    logic        ir32, ov32, ie32;
    logic [31:0] imm32;
    logic [1:0]  ec32;
    logic        ir64, ov64, ie64;
    logic [63:0] imm64;
    logic [7:0]  ec64;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  f;
    } ent_t;

    ent_t        q[$];
    int          cnt32 = 0;
    int          cnt64 = 0;
    logic [31:0] log_imm[$];
    int          log_cyc[$];

    always #5 clk = ~clk;

    aftab_imm_gen_pipe #(.XLEN(32), .ERRW(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(ir32),
        .i_instr(i_instr), .i_fmt(i_fmt),
        .o_out_valid(ov32), .i_out_ready(i_out_ready),
        .o_imm(imm32), .o_imm_err(ie32), .o_err_cnt(ec32),
        .i_clr_err(i_clr_err)
    );

    aftab_imm_gen_pipe #(.XLEN(64), .ERRW(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(ir64),
        .i_instr(i_instr), .i_fmt(i_fmt),
        .o_out_valid(ov64), .i_out_ready(i_out_ready),
        .o_imm(imm64), .o_imm_err(ie64), .o_err_cnt(ec64),
        .i_clr_err(i_clr_err)
    );

    // Immediate value from the field rules, using signed shifts on a 64-bit value.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] f,
                                            input int xlen);
        longint s;
        longint v;
        s = longint'($signed(ins));
        case (f)
            3'd0: v = s >>> 20;
            3'd1: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd2: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                      | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd3: v = (s >>> 12) <<< 12;
            3'd4: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                      | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] f,
                        input logic ordy, input logic clr);
        i_in_valid  = v;
        i_instr     = ins;
        i_fmt       = f;
        i_out_ready = ordy;
        i_clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference occupancy: a FIFO of at most two entries plus error counters.
    initial begin
        logic acc;
        logic del;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                cnt32 = 0;
                cnt64 = 0;
            end else begin
                cyc++;
                acc = i_in_valid && (q.size() < 2);
                del = (q.size() > 0) && i_out_ready;
                if (i_clr_err) begin
                    cnt32 = 0;
                    cnt64 = 0;
                end else if (acc && i_fmt == 3'd7) begin
                    if (cnt32 < 3)   cnt32++;
                    if (cnt64 < 255) cnt64++;
                end
                if (del) void'(q.pop_front());
                if (acc) q.push_back('{ins: i_instr, f: i_fmt});
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready32", 64'(ir32), 64'(q.size() < 2));
                chk("in_ready64", 64'(ir64), 64'(q.size() < 2));
                chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
                chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
                chk("err_cnt32", 64'(ec32), 64'(cnt32));
                chk("err_cnt64", 64'(ec64), 64'(cnt64));
                if (q.size() > 0) begin
                    e = ref_imm(q[0].ins, q[0].f, 32);
                    chk("imm32", 64'(imm32), 64'(e[31:0]));
                    e = ref_imm(q[0].ins, q[0].f, 64);
                    chk("imm64", imm64, e);
                    chk("imm_err32", 64'(ie32), 64'(q[0].f == 3'd7));
                    chk("imm_err64", 64'(ie64), 64'(q[0].f == 3'd7));
                end
                if (ov32 && i_out_ready) begin
                    log_imm.push_back(imm32);
                    log_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the immediate model with hand-computed values.
        chk("model_I32", ref_imm(32'hFFF00093, 3'd0, 32) & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        chk("model_B64", ref_imm(32'h8000_0863, 3'd2, 64), 64'hFFFF_FFFF_FFFF_F010);
        chk("model_J64", ref_imm(32'h0080006F, 3'd4, 64), 64'h8);
        chk("model_SH32", ref_imm(32'h03F01013, 3'd6, 32), 64'h1F);
        chk("model_SH64", ref_imm(32'h03F01013, 3'd6, 64), 64'h3F);
        chk("model_U", ref_imm(32'h12345037, 3'd3, 64), 64'h1234_5000);
        chk("model_Z", ref_imm(32'h0002D073, 3'd5, 64), 64'h5);

        // Reset values.
        #1;
        chk("rst_in_ready", 64'(ir32), 64'h1);
        chk("rst_out_valid", 64'(ov32), 64'h0);
        chk("rst_imm", 64'(imm32), 64'h0);
        chk("rst_imm_err", 64'(ie32), 64'h0);
        chk("rst_err_cnt", 64'(ec64), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-cycle latency and back-to-back throughput.
        step(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0);
        chk("I_valid", 64'(ov32), 64'h1);
        chk("I_imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("I_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, 32'h8000_0863, 3'd2, 1'b1, 1'b0);
        chk("B_imm64", imm64, 64'hFFFF_FFFF_FFFF_F010);
        chk("B_imm32", 64'(imm32), 64'hFFFF_F010);
        step(1'b1, 32'h0080006F, 3'd4, 1'b1, 1'b0);
        chk("J_imm64", imm64, 64'h8);
        step(1'b1, 32'h03F01013, 3'd6, 1'b1, 1'b0);
        chk("SH_imm32", 64'(imm32), 64'h1F);
        chk("SH_imm64", imm64, 64'h3F);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        chk("drain_valid", 64'(ov32), 64'h0);

        // Backpressure: two accepted into M and K, third held off.
        log_imm.delete();
        log_cyc.delete();
        step(1'b1, 32'h00500093, 3'd0, 1'b0, 1'b0);
        chk("bp_ready_c1", 64'(ir32), 64'h1);
        step(1'b1, 32'h12345037, 3'd3, 1'b0, 1'b0);
        chk("bp_ready_c2", 64'(ir32), 64'h0);
        chk("bp_imm_c2", 64'(imm32), 64'h5);
        step(1'b1, 32'h0002D073, 3'd5, 1'b0, 1'b0);
        chk("bp_ready_c3", 64'(ir32), 64'h0);
        chk("bp_hold_imm", 64'(imm32), 64'h5);
        step(1'b1, 32'h0002D073, 3'd5, 1'b1, 1'b0);
        chk("bp_ready_rise", 64'(ir32), 64'h1);
        chk("bp_imm_k", 64'(imm32), 64'h1234_5000);
        step(1'b1, 32'h0002D073, 3'd5, 1'b1, 1'b0);
        chk("bp_imm_z", 64'(imm32), 64'h5);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        chk("bp_empty", 64'(ov32), 64'h0);
        chk("bp_log_size", 64'(log_imm.size()), 64'd3);
        if (log_imm.size() == 3) begin
            chk("bp_order0", 64'(log_imm[0]), 64'h5);
            chk("bp_order1", 64'(log_imm[1]), 64'h1234_5000);
            chk("bp_order2", 64'(log_imm[2]), 64'h5);
            chk("bp_gap01", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
            chk("bp_gap12", 64'(log_cyc[2] - log_cyc[1]), 64'd1);
        end

        // Reserved format: saturation at 3 for ERRW=2, then clear beats increment.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'hFFFF_FFFF, 3'd7, 1'b1, 1'b0);
            chk("rsv_err", 64'(ie32), 64'h1);
            chk("rsv_imm", 64'(imm32), 64'h0);
        end
        chk("rsv_sat32", 64'(ec32), 64'd3);
        chk("rsv_cnt64", 64'(ec64), 64'd5);
        step(1'b1, 32'hFFFF_FFFF, 3'd7, 1'b1, 1'b1);
        chk("rsv_clr32", 64'(ec32), 64'd0);
        chk("rsv_clr64", 64'(ec64), 64'd0);
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Asynchronous reset while FULL.
        step(1'b1, 32'h12345037, 3'd3, 1'b0, 1'b0);
        step(1'b1, 32'h0, 3'd7, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(ir32), 64'h0);
        chk("pre_rst_cnt", 64'(ec32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(ir32), 64'h1);
        chk("arst_out_valid", 64'(ov32), 64'h0);
        chk("arst_imm32", 64'(imm32), 64'h0);
        chk("arst_imm64", imm64, 64'h0);
        chk("arst_err_cnt", 64'(ec32), 64'h0);
        i_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
            chk("post_rst_empty", 64'(ov32), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
